// File: rtl/fetch_unit.sv
// Instruction-fetch stage: issues one imem read per PC, absorbs memory latency,
// decode stalls (one-entry skid) and branch-redirect flushes into IF/ID.
module fetch_unit #(
  parameter logic [15:0] RESET_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc_cur,
  output logic        pc_hold,
  output logic [15:0] pc_next_seq,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_done,
  input  logic [15:0] imem_data,
  input  logic        stall_id,
  input  logic        flush,
  output logic        ifid_valid,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc_plus2
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_FULL,
    S_DISCARD
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] req_pc;
  logic [15:0] skid_instr;
  logic [15:0] load_instr;
  logic        load_ok;
  logic        advance;
  logic        skid_load;

  assign pc_next_seq = pc_cur + 16'd2;
  assign imem_addr   = pc_cur;
  assign load_ok     = !ifid_valid || !stall_id;

  always_comb begin
    state_nxt  = state;
    imem_req   = 1'b0;
    advance    = 1'b0;
    skid_load  = 1'b0;
    load_instr = skid_instr;
    unique case (state)
      S_REQ: begin
        imem_req  = 1'b1;
        state_nxt = flush ? S_DISCARD : S_WAIT;
      end
      S_WAIT: begin
        if (imem_done) begin
          if (flush) begin
            state_nxt = S_REQ;
          end else if (load_ok) begin
            advance    = 1'b1;
            load_instr = imem_data;
            state_nxt  = S_REQ;
          end else begin
            skid_load = 1'b1;
            state_nxt = S_FULL;
          end
        end else if (flush) begin
          state_nxt = S_DISCARD;
        end
      end
      S_FULL: begin
        if (flush) begin
          state_nxt = S_REQ;
        end else if (!stall_id) begin
          advance   = 1'b1;
          state_nxt = S_REQ;
        end
      end
      S_DISCARD: begin
        if (imem_done) state_nxt = S_REQ;
      end
      default: state_nxt = S_REQ;
    endcase
    // Reset masks the request and freezes the PC regardless of state.
    if (rst) imem_req = 1'b0;
    pc_hold = rst ? 1'b1 : !(advance || flush);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_REQ;
      req_pc        <= '0;
      skid_instr    <= RESET_INSTR;
      ifid_valid    <= 1'b0;
      ifid_instr    <= RESET_INSTR;
      ifid_pc_plus2 <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_REQ) req_pc <= pc_cur;
      if (skid_load) skid_instr <= imem_data;
      if (flush) begin
        ifid_valid    <= 1'b0;
        ifid_instr    <= RESET_INSTR;
        ifid_pc_plus2 <= '0;
      end else if (advance) begin
        ifid_valid    <= 1'b1;
        ifid_instr    <= load_instr;
        ifid_pc_plus2 <= req_pc + 16'd2;
      end else if (!stall_id) begin
        ifid_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: PC register and latency-programmable
// instruction memory modelled here; scoreboard of expected IF/ID contents.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc_cur;
  logic        pc_hold;
  logic [15:0] pc_next_seq;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_done;
  logic [15:0] imem_data;
  logic        stall_id;
  logic        flush;
  logic        ifid_valid;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc_plus2;

  fetch_unit #(.RESET_INSTR(16'h0800)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_cur       (pc_cur),
    .pc_hold      (pc_hold),
    .pc_next_seq  (pc_next_seq),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_done    (imem_done),
    .imem_data    (imem_data),
    .stall_id     (stall_id),
    .flush        (flush),
    .ifid_valid   (ifid_valid),
    .ifid_instr   (ifid_instr),
    .ifid_pc_plus2(ifid_pc_plus2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pcp2;
  } sb_t;

  sb_t         sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          mem_lat = 1;
  int          mem_cnt = 0;
  logic [15:0] mem_raddr = '0;
  logic [15:0] exp_pc = '0;
  logic [15:0] flush_target = '0;
  logic        s_req, s_hold, s_done;
  logic [15:0] s_addr, s_seq;

  function automatic logic [15:0] mem_f(input logic [15:0] a);
    return 16'hA123 + (a * 16'h0101);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Memory: returns data L cycles after the request; a pending reply survives reset.
  task automatic mem_model();
    imem_done = 1'b0;
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_done = 1'b1;
        imem_data = mem_f(mem_raddr);
      end
    end
    if (imem_req && !rst) begin
      mem_cnt   = mem_lat;
      mem_raddr = imem_addr;
    end
  endtask

  task automatic tick();
    logic        ld, fl, hold;
    logic [15:0] nxt;
    sb_t         e;
    @(negedge clk);
    mem_model();
    #1;
    s_req  = imem_req;
    s_addr = imem_addr;
    s_hold = pc_hold;
    s_seq  = pc_next_seq;
    s_done = imem_done;
    if (rst) begin
      check_eq("rst_req", {31'd0, imem_req}, 32'd0);
      check_eq("rst_hold", {31'd0, pc_hold}, 32'd1);
    end else if (imem_req) begin
      check_eq("imem_addr", {16'd0, imem_addr}, {16'd0, exp_pc});
      e.instr = mem_f(exp_pc);
      e.pcp2  = exp_pc + 16'd2;
      sb_q.push_back(e);
    end
    hold = pc_hold;
    fl   = flush && !rst;
    ld   = !rst && !pc_hold && !flush;
    nxt  = flush ? flush_target : pc_next_seq;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      pc_cur = '0;
      exp_pc = '0;
      sb_q.delete();
    end else if (!hold) begin
      pc_cur = nxt;
    end
    if (fl) begin
      sb_q.delete();
      exp_pc = flush_target;
      check_eq("flush_valid", {31'd0, ifid_valid}, 32'd0);
      check_eq("flush_instr", {16'd0, ifid_instr}, 32'h0800);
      check_eq("flush_pcp2", {16'd0, ifid_pc_plus2}, 32'd0);
    end else if (ld) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check_eq("ifid_valid", {31'd0, ifid_valid}, 32'd1);
        check_eq("ifid_instr", {16'd0, ifid_instr}, {16'd0, e.instr});
        check_eq("ifid_pcp2", {16'd0, ifid_pc_plus2}, {16'd0, e.pcp2});
      end
      exp_pc = exp_pc + 16'd2;
    end
  endtask

  task automatic wait_req(input int max);
    for (int i = 0; i < max; i++) begin
      tick();
      if (s_req) return;
    end
    check_eq("req_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_valid(input int max);
    for (int i = 0; i < max; i++) begin
      tick();
      if (ifid_valid) return;
    end
    check_eq("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] held;
    int          last_cyc;
    rst = 1'b1; pc_cur = '0; stall_id = 1'b0; flush = 1'b0;
    imem_done = 1'b0; imem_data = '0;

    // Reset state
    do_reset();
    check_eq("rst_ifid_valid", {31'd0, ifid_valid}, 32'd0);
    check_eq("rst_ifid_instr", {16'd0, ifid_instr}, 32'h0800);
    check_eq("rst_ifid_pcp2", {16'd0, ifid_pc_plus2}, 32'd0);

    // L=1 first fetch
    mem_lat = 1;
    tick();
    check_eq("t1_req", {31'd0, s_req}, 32'd1);
    check_eq("t1_addr", {16'd0, s_addr}, 32'd0);
    tick();
    check_eq("t1_done", {31'd0, s_done}, 32'd1);
    check_eq("t1_hold", {31'd0, s_hold}, 32'd0);
    check_eq("t1_instr", {16'd0, ifid_instr}, 32'hA123);
    check_eq("t1_pcp2", {16'd0, ifid_pc_plus2}, 32'd2);
    tick();
    check_eq("t1_req2", {31'd0, s_req}, 32'd1);
    check_eq("t1_addr2", {16'd0, s_addr}, 32'd2);

    // L=3 throughput: one request per 4 cycles
    do_reset();
    mem_lat = 3;
    last_cyc = 0;
    for (int i = 0; i < 4; i++) begin
      wait_req(10);
      check_eq("tp_addr", {16'd0, s_addr}, i * 2);
      if (i > 0) check_eq("tp_gap", cyc - last_cyc, 32'd4);
      last_cyc = cyc;
    end

    // Reset while in WAIT; the late done lands in REQ and must be ignored
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_eq("rw_valid", {31'd0, ifid_valid}, 32'd0);
    tick();
    check_eq("rw_late_done", {31'd0, s_done}, 32'd1);
    check_eq("rw_req", {31'd0, s_req}, 32'd1);
    check_eq("rw_addr", {16'd0, s_addr}, 32'd0);
    tick();
    check_eq("rw_ignored", {31'd0, ifid_valid}, 32'd0);
    tick();
    tick();
    check_eq("rw_fetch_valid", {31'd0, ifid_valid}, 32'd1);
    check_eq("rw_fetch_instr", {16'd0, ifid_instr}, 32'hA123);

    // Decode stall for 5 cycles with a fetch completing into the skid
    mem_lat = 1;
    wait_valid(10);
    stall_id = 1'b1;
    held = ifid_instr;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("st_hold", {31'd0, s_hold}, 32'd1);
      check_eq("st_valid", {31'd0, ifid_valid}, 32'd1);
      check_eq("st_instr", {16'd0, ifid_instr}, {16'd0, held});
    end
    stall_id = 1'b0;
    tick();
    check_eq("st_release", {31'd0, s_hold}, 32'd0);

    // Flush together with stall while IF/ID is valid
    check_eq("fs_pre_valid", {31'd0, ifid_valid}, 32'd1);
    stall_id = 1'b1; flush = 1'b1; flush_target = 16'h0100;
    tick();
    stall_id = 1'b0; flush = 1'b0;
    wait_req(10);
    check_eq("fs_addr", {16'd0, s_addr}, 32'h0100);

    // Flush in WAIT with L=3: stale data dropped, next request to target
    mem_lat = 3;
    wait_valid(10);
    tick();
    tick();
    flush = 1'b1; flush_target = 16'h0040;
    tick();
    flush = 1'b0;
    tick();
    check_eq("fw_stale_done", {31'd0, s_done}, 32'd1);
    check_eq("fw_stale_hold", {31'd0, s_hold}, 32'd1);
    check_eq("fw_dropped", {31'd0, ifid_valid}, 32'd0);
    tick();
    check_eq("fw_req", {31'd0, s_req}, 32'd1);
    check_eq("fw_addr", {16'd0, s_addr}, 32'h0040);

    // Flush coincident with done: next state is REQ
    tick();
    tick();
    flush = 1'b1; flush_target = 16'h0080;
    tick();
    flush = 1'b0;
    check_eq("fd_done", {31'd0, s_done}, 32'd1);
    check_eq("fd_hold", {31'd0, s_hold}, 32'd0);
    tick();
    check_eq("fd_req", {31'd0, s_req}, 32'd1);
    check_eq("fd_addr", {16'd0, s_addr}, 32'h0080);

    // Wrap at 16'hFFFE
    flush = 1'b1; flush_target = 16'hFFFE;
    tick();
    flush = 1'b0;
    wait_req(10);
    check_eq("wr_addr", {16'd0, s_addr}, 32'hFFFE);
    check_eq("wr_seq", {16'd0, s_seq}, 32'd0);
    wait_valid(10);
    check_eq("wr_pcp2", {16'd0, ifid_pc_plus2}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
